mem_wb_stage: RTL and testbench

- Consumer side of the EX/MEM pipeline register: takes the registered M-stage fields and performs the data-memory access.
- Access covers sub-word store byte-enables, load extension and write-data selection.
- Result is registered into the MEM/WB boundary with Tnew decremented.
- Also drives the combinational M-stage forwarding value used by the hazard unit.

---
 rtl/mem_wb_stage_pkg.sv | 27 ++
 rtl/mem_wb_stage_dm_ram.sv | 36 +++
 rtl/mem_wb_stage.sv | 132 +++++++++++++
 tb/tb_mem_wb_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the M stage: memory-op kinds, write-data selects,
// the reset value of the MEM/WB register and the Tnew countdown helper.
package mem_wb_stage_pkg;

    typedef enum logic [2:0] {
        MOP_W  = 3'd0,   // word (codes 5-7 also behave as word)
        MOP_BU = 3'd1,   // byte, zero-extended
        MOP_BS = 3'd2,   // byte, sign-extended
        MOP_HU = 3'd3,   // halfword, zero-extended
        MOP_HS = 3'd4    // halfword, sign-extended
    } mem_op_e;

    typedef enum logic [1:0] {
        WD_AO  = 2'd0,   // ALU result
        WD_DM  = 2'd1,   // load data
        WD_PC8 = 2'd2,   // link address PC+8
        WD_AO3 = 2'd3    // alias of WD_AO
    } wd_sel_e;

    localparam logic [31:0] RESET_ZERO = 32'd0;

    // Cycles-until-ready counts down by one per stage and stops at zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/mem_wb_stage_dm_ram.sv
// Data memory: word-organised array with per-byte write enables,
// asynchronous clear and a combinational read of the addressed word.
module dm_ram #(
    parameter int DM_WORDS = 4096,
    parameter int DM_AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DM_AW-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DM_WORDS];

    // Clear the array on reset; otherwise write the enabled byte lanes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array really is cleared here because loads of words never
            // written must return zero; this rules out mapping it onto block RAM.
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// M stage: data-memory access (sub-word stores, load extension), write-data
// selection, the M-stage forwarding value and the MEM/WB pipeline register.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DM_WORDS = 4096,
    parameter int DM_AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    input  logic [31:0] AO_i,
    input  logic [31:0] RD2_i,
    input  logic [4:0]  a3_i,
    input  logic        RegWE_i,
    input  logic [1:0]  Tnew_i,
    input  logic [31:0] pcadd4_i,
    input  logic        MemWE_i,
    input  logic [2:0]  mem_op_i,
    input  logic [1:0]  wd_sel_i,
    output logic [31:0] fwd_M_o,
    output logic [31:0] pc_o,
    output logic [4:0]  a3_o,
    output logic        RegWE_o,
    output logic [1:0]  Tnew_o,
    output logic [31:0] wd_o,
    output logic        align_err_o
);

    logic [DM_AW-1:0] word_idx;
    logic             is_byte, is_half;
    logic             range_err, misalign, err;
    logic [3:0]       be;
    logic [31:0]      st_data, rd_word, rd_shift, ld_data, link_addr, wd_next;

    assign word_idx  = AO_i[DM_AW+1:2];
    assign is_byte   = (mem_op_i == MOP_BU) || (mem_op_i == MOP_BS);
    assign is_half   = (mem_op_i == MOP_HU) || (mem_op_i == MOP_HS);
    // Any set bit above the array's byte range means the address is past the end.
    assign range_err = |AO_i[31:DM_AW+2];
    assign misalign  = is_half ? AO_i[0] : (!is_byte && (AO_i[1:0] != 2'b00));
    assign err       = (MemWE_i || (wd_sel_i == WD_DM)) && (range_err || misalign);
    assign link_addr = pcadd4_i + 32'd4;

    // Byte enables and lane-replicated store data for the access size.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        be      = 4'b0000;
        st_data = RD2_i;
        if (MemWE_i && !err) begin
            if (is_byte) begin
                be      = 4'b0001 << AO_i[1:0];
                st_data = {4{RD2_i[7:0]}};
            end else if (is_half) begin
                be      = AO_i[1] ? 4'b1100 : 4'b0011;
                st_data = {2{RD2_i[15:0]}};
            end else begin
                be      = 4'b1111;
            end
        end
    end

    dm_ram #(
        .DM_WORDS (DM_WORDS),
        .DM_AW    (DM_AW)
    ) u_dm_ram (
        .clk   (clk),
        .reset (reset),
        .addr  (word_idx),
        .be    (be),
        .wdata (st_data),
        .rdata (rd_word)
    );

    assign rd_shift = rd_word >> {AO_i[1:0], 3'b000};

    // Extract the addressed lane and extend it; faulting loads read as zero.
    always_comb begin
        ld_data = rd_word;
        case (mem_op_i)
            MOP_BU:  ld_data = {24'd0, rd_shift[7:0]};
            MOP_BS:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            MOP_HU:  ld_data = {16'd0, rd_shift[15:0]};
            MOP_HS:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
        if (err) begin
            ld_data = RESET_ZERO;
        end
    end

    // Write-back data and forward value; loads are never forwarded from M.
    always_comb begin
        wd_next = AO_i;
        fwd_M_o = AO_i;
        case (wd_sel_i)
            WD_DM: begin
                wd_next = ld_data;
                fwd_M_o = RESET_ZERO;
            end
            WD_PC8: begin
                wd_next = link_addr;
                fwd_M_o = link_addr;
            end
            default: begin
                wd_next = AO_i;
                fwd_M_o = AO_i;
            end
        endcase
    end

    // MEM/WB pipeline register; a faulting access never writes the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_o        <= RESET_ZERO;
            a3_o        <= '0;
            RegWE_o     <= 1'b0;
            Tnew_o      <= '0;
            wd_o        <= RESET_ZERO;
            align_err_o <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
            pc_o        <= pc_i;
            a3_o        <= a3_i;
            RegWE_o     <= RegWE_i & ~err;
            Tnew_o      <= tnew_dec(Tnew_i);
            wd_o        <= wd_next;
            align_err_o <= err;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stores/loads of every width, alignment and
// range faults, Tnew countdown, forwarding/link value and reset behaviour.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_i, AO_i, RD2_i, pcadd4_i;
    logic [4:0]  a3_i;
    logic        RegWE_i, MemWE_i;
    logic [1:0]  Tnew_i, wd_sel_i;
    logic [2:0]  mem_op_i;
    logic [31:0] fwd_M_o, pc_o, wd_o;
    logic [4:0]  a3_o;
    logic        RegWE_o, align_err_o;
    logic [1:0]  Tnew_o;

    int n_cmp = 0;
    int n_mis = 0;

    mem_wb_stage #(.DM_WORDS(4096), .DM_AW(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_i        (pc_i),
        .AO_i        (AO_i),
        .RD2_i       (RD2_i),
        .a3_i        (a3_i),
        .RegWE_i     (RegWE_i),
        .Tnew_i      (Tnew_i),
        .pcadd4_i    (pcadd4_i),
        .MemWE_i     (MemWE_i),
        .mem_op_i    (mem_op_i),
        .wd_sel_i    (wd_sel_i),
        .fwd_M_o     (fwd_M_o),
        .pc_o        (pc_o),
        .a3_o        (a3_o),
        .RegWE_o     (RegWE_o),
        .Tnew_o      (Tnew_o),
        .wd_o        (wd_o),
        .align_err_o (align_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs change right after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] mop, input logic [1:0] wsel, input logic [31:0] ao,
                      input logic [31:0] rd2, input logic we, input logic rwe, input logic [4:0] a3);
        mem_op_i = mop;  wd_sel_i = wsel; AO_i = ao; RD2_i = rd2;
        MemWE_i  = we;   RegWE_i  = rwe;  a3_i = a3;
    endtask

    // Issue a load with write-back of load data and return the registered result.
    task automatic load(input string tag, input logic [2:0] mop, input logic [31:0] ao,
                        input logic [31:0] exp);
        op(mop, 2'd1, ao, 32'd0, 1'b0, 1'b1, 5'd9);
        step();
        check(tag, wd_o, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        pc_i = '0; pcadd4_i = '0; Tnew_i = '0;
        op(3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_wd", wd_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);

        // Make the register non-zero, then reset between edges.
        pc_i = 32'h100; Tnew_i = 2'd2;
        op(3'd0, 2'd0, 32'h55, 32'd0, 1'b0, 1'b1, 5'd5);
        step();
        check("pre_pc", pc_o, 32'h100);
        check("pre_wd", wd_o, 32'h55);
        #2 reset = 1'b1;
        #1;
        check("arst_pc", pc_o, 32'd0);
        check("arst_wd", wd_o, 32'd0);
        check("arst_a3", {27'd0, a3_o}, 32'd0);
        check("arst_we", {31'd0, RegWE_o}, 32'd0);
        check("arst_tn", {30'd0, Tnew_o}, 32'd0);
        #1 reset = 1'b0;
        pc_i = 32'h0; Tnew_i = 2'd0;
        load("rst_load", 3'd0, 32'h10, 32'd0);

        // Word store then load.
        op(3'd0, 2'd0, 32'h10, 32'h12345678, 1'b1, 1'b0, 5'd0);
        step();
        check("sw_err", {31'd0, align_err_o}, 32'd0);
        op(3'd0, 2'd1, 32'h10, 32'd0, 1'b0, 1'b1, 5'd8);
        #1 check("lw_fwd", fwd_M_o, 32'd0);
        step();
        check("lw_wd", wd_o, 32'h12345678);
        check("lw_we", {31'd0, RegWE_o}, 32'd1);
        check("lw_a3", {27'd0, a3_o}, 32'd8);

        // Sub-word stores and loads.
        op(3'd1, 2'd0, 32'h11, 32'hFFFFFFAB, 1'b1, 1'b0, 5'd0);
        step();
        load("sb_word", 3'd0, 32'h10, 32'h1234AB78);
        load("lb",      3'd2, 32'h11, 32'hFFFFFFAB);
        load("lbu",     3'd1, 32'h11, 32'h000000AB);
        op(3'd3, 2'd0, 32'h12, 32'hFFFF8001, 1'b1, 1'b0, 5'd0);
        step();
        load("lh",      3'd4, 32'h12, 32'hFFFF8001);
        load("lhu",     3'd3, 32'h12, 32'h00008001);
        load("sh_word", 3'd0, 32'h10, 32'h8001AB78);
        load("lb_pos",  3'd2, 32'h10, 32'h00000078);
        load("lbu_b3",  3'd1, 32'h13, 32'h00000080);
        load("lh_lo",   3'd4, 32'h10, 32'hFFFFAB78);
        load("op7_w",   3'd7, 32'h10, 32'h8001AB78);

        // Misalignment and range.
        op(3'd0, 2'd1, 32'h13, 32'd0, 1'b0, 1'b1, 5'd8);
        step();
        check("mis_err", {31'd0, align_err_o}, 32'd1);
        check("mis_we",  {31'd0, RegWE_o}, 32'd0);
        check("mis_wd",  wd_o, 32'd0);
        op(3'd4, 2'd1, 32'h11, 32'd0, 1'b0, 1'b1, 5'd8);
        step();
        check("mish_err", {31'd0, align_err_o}, 32'd1);
        op(3'd0, 2'd0, 32'h4000, 32'hDEADBEEF, 1'b1, 1'b1, 5'd3);
        step();
        check("rng_err", {31'd0, align_err_o}, 32'd1);
        check("rng_we",  {31'd0, RegWE_o}, 32'd0);
        check("rng_wd",  wd_o, 32'h4000);
        load("rng_nowr",  3'd0, 32'h0, 32'd0);
        op(3'd0, 2'd0, 32'h22, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0);
        step();
        load("missw_nowr", 3'd0, 32'h20, 32'd0);
        op(3'd0, 2'd0, 32'h3FFC, 32'hA5A5A5A5, 1'b1, 1'b0, 5'd0);
        step();
        check("top_err", {31'd0, align_err_o}, 32'd0);
        load("top_word", 3'd0, 32'h3FFC, 32'hA5A5A5A5);

        // Tnew countdown.
        op(3'd0, 2'd0, 32'h1, 32'd0, 1'b0, 1'b0, 5'd0);
        Tnew_i = 2'd2; step(); check("tnew2", {30'd0, Tnew_o}, 32'd1);
        Tnew_i = 2'd0; step(); check("tnew0", {30'd0, Tnew_o}, 32'd0);
        Tnew_i = 2'd3; step(); check("tnew3", {30'd0, Tnew_o}, 32'd2);
        Tnew_i = 2'd1; step(); check("tnew1", {30'd0, Tnew_o}, 32'd0);
        Tnew_i = 2'd0;

        // Link address and forwarding.
        pcadd4_i = 32'h3004;
        op(3'd0, 2'd2, 32'h777, 32'd0, 1'b0, 1'b1, 5'd31);
        #1 check("pc8_fwd", fwd_M_o, 32'h3008);
        step();
        check("pc8_wd", wd_o, 32'h3008);
        check("pc8_a3", {27'd0, a3_o}, 32'd31);
        op(3'd0, 2'd3, 32'h777, 32'd0, 1'b0, 1'b1, 5'd0);
        #1 check("ao3_fwd", fwd_M_o, 32'h777);
        step();
        check("ao3_wd", wd_o, 32'h777);
        check("zero_a3", {27'd0, a3_o}, 32'd0);

        // Reset held across a store edge: the write is lost.
        op(3'd0, 2'd0, 32'h20, 32'hCAFEF00D, 1'b1, 1'b1, 5'd4);
        #1 reset = 1'b1;
        step();
        check("rstst_wd", wd_o, 32'd0);
        check("rstst_we", {31'd0, RegWE_o}, 32'd0);
        op(3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        reset = 1'b0;
        load("rstst_load", 3'd0, 32'h20, 32'd0);
        load("rst_clr10",  3'd0, 32'h10, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
